// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - cpu/dbg request ports and dmem bus between the arbiter and its environment
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_wren;
    logic              cpu_lock;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_wren;
    logic              dbg_lock;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic [ADDR_W-1:0] address_dmem;
    logic [DATA_W-1:0] data;
    logic              wren;
    logic [DATA_W-1:0] q_dmem;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_wren, cpu_lock, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_wren, dbg_lock, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output address_dmem, data, wren,
        input  q_dmem
    );

    // Requesters plus the memory itself
    modport master (
        output cpu_req, cpu_wren, cpu_lock, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_wren, dbg_lock, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  address_dmem, data, wren,
        output q_dmem
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - two-master dmem arbiter with bounded locks; DMEM_ARB_RR_EN selects round-robin over cpu-first priority
module dmem_port_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    dmem_port_arbiter_if.slave    bus
);
    localparam int              CNT_W    = $clog2(LOCK_MAX + 1);
    // A lock entered from IDLE already used one cycle, so the last owned cycle sees LOCK_MAX-1
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);
    localparam bit              CAN_LOCK = (LOCK_MAX > 1);

    typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_DBG} state_t;
    typedef enum logic {OWNER_CPU, OWNER_DBG} owner_t;

    state_t            state, state_nxt;
    owner_t            last_owner, last_owner_nxt;
    logic [CNT_W-1:0]  lock_cnt, lock_cnt_nxt;
    logic              cpu_pick;
    logic              cpu_gnt, dbg_gnt;
    logic              cpu_rvalid, dbg_rvalid;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] data_mux;
    logic              wren_mux;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_owner <= OWNER_DBG;
            lock_cnt   <= '0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            lock_cnt   <= lock_cnt_nxt;
            cpu_rvalid <= cpu_gnt & ~bus.cpu_wren;
            dbg_rvalid <= dbg_gnt & ~bus.dbg_wren;
        end
    end

`ifdef DMEM_ARB_RR_EN
    assign cpu_pick = bus.cpu_req && (!bus.dbg_req || last_owner == OWNER_DBG);
`else
    assign cpu_pick = bus.cpu_req;
`endif

    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        lock_cnt_nxt   = lock_cnt;
        cpu_gnt        = 1'b0;
        dbg_gnt        = 1'b0;
        case (state)
            IDLE: begin
                cpu_gnt = cpu_pick;
                dbg_gnt = bus.dbg_req && !cpu_pick;
                if (cpu_gnt) begin
                    last_owner_nxt = OWNER_CPU;
                    if (bus.cpu_lock && CAN_LOCK) begin
                        state_nxt    = OWN_CPU;
                        lock_cnt_nxt = CNT_W'(1);
                    end
                end else if (dbg_gnt) begin
                    last_owner_nxt = OWNER_DBG;
                    if (bus.dbg_lock && CAN_LOCK) begin
                        state_nxt    = OWN_DBG;
                        lock_cnt_nxt = CNT_W'(1);
                    end
                end
            end
            OWN_CPU: begin
                cpu_gnt      = bus.cpu_req;
                lock_cnt_nxt = lock_cnt + CNT_W'(1);
                if ((bus.cpu_req && !bus.cpu_lock) || lock_cnt == CNT_LAST) begin
                    state_nxt    = IDLE;
                    lock_cnt_nxt = '0;
                end
            end
            OWN_DBG: begin
                dbg_gnt      = bus.dbg_req;
                lock_cnt_nxt = lock_cnt + CNT_W'(1);
                if ((bus.dbg_req && !bus.dbg_lock) || lock_cnt == CNT_LAST) begin
                    state_nxt    = IDLE;
                    lock_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = IDLE;
                lock_cnt_nxt = '0;
            end
        endcase
        // Grants are combinational from req, so they must be suppressed explicitly while in reset
        if (!reset) begin
            cpu_gnt = 1'b0;
            dbg_gnt = 1'b0;
        end
    end

    always_comb begin
        addr_mux = '0;
        data_mux = '0;
        wren_mux = 1'b0;
        if (cpu_gnt) begin
            addr_mux = bus.cpu_addr;
            data_mux = bus.cpu_wdata;
            wren_mux = bus.cpu_wren;
        end else if (dbg_gnt) begin
            addr_mux = bus.dbg_addr;
            data_mux = bus.dbg_wdata;
            wren_mux = bus.dbg_wren;
        end
    end

    assign bus.address_dmem = addr_mux;
    assign bus.data         = data_mux;
    assign bus.wren         = wren_mux;
    assign bus.cpu_gnt      = cpu_gnt;
    assign bus.dbg_gnt      = dbg_gnt;
    assign bus.cpu_rvalid   = cpu_rvalid;
    assign bus.dbg_rvalid   = dbg_rvalid;
    assign bus.cpu_rdata    = bus.q_dmem;
    assign bus.dbg_rdata    = bus.q_dmem;
endmodule
